down_timer_ctrl: RTL and testbench
==================================

Name: down_timer_ctrl

Overview:
- Command-driven controller that sequences an 8-bit-class down counter as a programmable countdown timer.
- Supports one-shot and periodic (auto-reload) modes, pause/resume and abort.
- Signals expiry with a pulse and a sticky interrupt flag.
- Sits between a register/CPU command interface and the counter datapath; firmware sets up timers through it.

Parameters:
- WIDTH, 8, counter and reload width in bits.
- PRESC_DIV, 4, tick divider ratio; used only when DTC_PRESCALER_EN is defined; must be >= 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  00 START, 01 PAUSE, 10 RESUME, 11 ABORT.
- cmd_load  in  WIDTH  reload value; sampled on START only.
- cmd_periodic  in  1  mode; 1 = auto-reload, sampled on START only.
- count  out  WIDTH  current counter value.
- state_o  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE.
- expire  out  1  one-cycle pulse on expiry.
- irq  out  1  sticky expiry flag.
- irq_clr  in  1  clears irq.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state IDLE, count=0, reload=0, periodic=0, expire=0, irq=0, prescaler=0. Reset mid-run aborts immediately, with no expire pulse.
- tick: 1 every cycle without the optional feature.
- Expiry event: state RUN && tick && count==0.
- cmd_ready: 0 in the expiry-event cycle; 1 otherwise (0 during reset). A command held while cmd_ready=0 is accepted on the next cycle.
- Commands take effect on the clock edge of acceptance and are visible the next cycle.
- IDLE:
  - START: reload<=cmd_load, periodic<=cmd_periodic, count<=cmd_load, go RUN.
  - PAUSE, RESUME, ABORT: accepted, no effect.
- RUN:
  - No command, tick, count!=0: count<=count-1.
  - Expiry event: expire=1 that cycle. If periodic, count<=reload and stay RUN; else go DONE with count held at 0.
  - Period is therefore reload+1 ticks. START with load 0 expires on the first tick.
  - PAUSE: go PAUSE, count holds; a decrement due the same cycle is dropped.
  - START: restart with the new values, no expire.
  - ABORT: go IDLE, count<=0.
  - RESUME: ignored.
- PAUSE:
  - RESUME: go RUN; decrementing resumes on the next tick.
  - ABORT: go IDLE, count<=0.
  - START: restart as in IDLE.
  - PAUSE: ignored.
- DONE:
  - START: restart as in IDLE.
  - ABORT: go IDLE, count<=0.
  - Others: ignored.
- irq: set on expire; cleared by irq_clr. Set wins if expire and irq_clr coincide.
- Arithmetic: modulo 2^WIDTH. Count never wraps below 0, because the 0 case is always handled as expiry.

Optional Feature:
- Macro DTC_PRESCALER_EN.
- Defined: a prescaler counter runs 0..PRESC_DIV-1 in RUN; tick=1 when it equals PRESC_DIV-1, then it wraps to 0.
  - Cleared to 0 on START and ABORT.
  - Holds its value in PAUSE.
  - Period becomes (reload+1)*PRESC_DIV cycles.
- Undefined: no prescaler logic, tick=1, and PRESC_DIV is unused.

Decomposition:
- Package dtc_pkg holds:
  - the state enum (IDLE/RUN/PAUSE/DONE);
  - the cmd_op encodings (OP_START, OP_PAUSE, OP_RESUME, OP_ABORT);
  - WIDTH default constant.
- One natural sub-module, dtc_down_counter: loadable down counter with load, load_val, dec and clear, and a zero flag.
  - Synchronous active-high reset to 0.
  - The controller owns all sequencing.

Test Plan:
- Reset then START load=3, one-shot -> count 3,2,1,0 on successive cycles; expire pulse in the 4th RUN cycle; state DONE; irq=1; count stays 0.
- START load=2, periodic -> expire every 3 cycles, count 2,1,0,2,1,0; cmd_ready=0 exactly in expire cycles; irq_clr coinciding with expire leaves irq=1.
- START load=10; PAUSE at count 6 -> count holds 6 for 5 cycles; RESUME -> 5,4,...; expire 7 cycles after RESUME.
- START load=5, then ABORT at count 3 -> IDLE, count 0, no expire; START load=0 one-shot -> expire on the first RUN cycle.
- Assert rst for one cycle mid-RUN at count 4 -> all outputs return to reset values next cycle, no expire pulse.
- With DTC_PRESCALER_EN and PRESC_DIV=4: START load=1 one-shot -> count decrements every 4 cycles; expire at cycle 8 after START.

Source files
------------

// File: rtl/dtc_pkg.sv
// Shared types and constants for the down_timer_ctrl countdown timer.
// Holds the FSM state encoding, command opcodes and default datapath width.
package dtc_pkg;

    localparam int DTC_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } dtc_state_t;

    typedef enum logic [1:0] {
        OP_START  = 2'b00,
        OP_PAUSE  = 2'b01,
        OP_RESUME = 2'b10,
        OP_ABORT  = 2'b11
    } dtc_op_t;

endpackage

// File: rtl/dtc_down_counter.sv
// Loadable down counter with clear, load and decrement (priority in that order).
// Latency: one cycle from control to count; exposes a combinational zero flag.
module dtc_down_counter
    import dtc_pkg::*;
#(
    parameter int WIDTH = DTC_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_count,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/down_timer_ctrl.sv
// Command-driven countdown timer: one-shot/periodic, pause/resume/abort, expiry pulse + sticky irq.
// Optional tick prescaler enabled by defining DTC_PRESCALER_EN; cmd_ready drops only in expiry cycles.
module down_timer_ctrl
    import dtc_pkg::*;
#(
    parameter int WIDTH     = DTC_WIDTH,
    parameter int PRESC_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_load,
    input  logic             cmd_periodic,
    output logic [WIDTH-1:0] count,
    output logic [1:0]       state_o,
    output logic             expire,
    output logic             irq,
    input  logic             irq_clr
);

    dtc_state_t       r_state;
    logic [WIDTH-1:0] r_reload;
    logic             r_periodic;
    logic             r_irq;

    logic             w_tick;
    logic             w_zero;
    logic             w_expire;
    logic             w_ready;
    logic             w_acc;
    dtc_op_t          w_op;
    logic             w_start;
    logic             w_abort;
    logic             w_pause_run;
    logic             w_resume_pause;
    logic             w_load;
    logic [WIDTH-1:0] w_load_val;
    logic             w_dec;

    assign w_op     = dtc_op_t'(cmd_op);
    assign w_expire = (r_state == ST_RUN) && w_tick && w_zero;
    // Commands are refused in the expiry cycle so reload/DONE never races a command.
    assign w_ready  = !rst && !w_expire;
    assign w_acc    = cmd_valid && w_ready;

    assign w_start        = w_acc && (w_op == OP_START);
    assign w_abort        = w_acc && (w_op == OP_ABORT);
    assign w_pause_run    = w_acc && (w_op == OP_PAUSE)  && (r_state == ST_RUN);
    assign w_resume_pause = w_acc && (w_op == OP_RESUME) && (r_state == ST_PAUSE);

    assign w_load     = w_start || (w_expire && r_periodic);
    assign w_load_val = w_start ? cmd_load : r_reload;
    assign w_dec      = (r_state == ST_RUN) && w_tick && !w_zero
                        && !w_pause_run && !w_start && !w_abort;

`ifdef DTC_PRESCALER_EN
    localparam int PW = $clog2(PRESC_DIV);
    logic [PW-1:0] r_presc;

    assign w_tick = (r_presc == PW'(PRESC_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_start || w_abort) begin
            r_presc <= '0;
        end else if ((r_state == ST_RUN) && !w_pause_run) begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
        end
    end
`else
    assign w_tick = 1'b1;
`endif

    dtc_down_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_abort),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_count    (count),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_reload   <= '0;
            r_periodic <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_irq <= w_expire || (r_irq && !irq_clr);
            if (w_start) begin
                r_reload   <= cmd_load;
                r_periodic <= cmd_periodic;
                r_state    <= ST_RUN;
            end else if (w_abort) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_RUN: begin
                        if (w_expire && !r_periodic) begin
                            r_state <= ST_DONE;
                        end else if (w_pause_run) begin
                            r_state <= ST_PAUSE;
                        end
                    end
                    ST_PAUSE: begin
                        if (w_resume_pause) begin
                            r_state <= ST_RUN;
                        end
                    end
                    default: r_state <= r_state;
                endcase
            end
        end
    end

    assign cmd_ready = w_ready;
    assign state_o   = r_state;
    assign expire    = w_expire;
    assign irq       = r_irq;

endmodule

// File: tb/tb_down_timer_ctrl.sv
// Directed bench for down_timer_ctrl: per-cycle expectations queued at drive time, popped at negedge.
// Define DTC_PRESCALER_EN to run the prescaled sequence instead of the default one.
module tb_down_timer_ctrl;

    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_DONE = 2'd3;
    localparam logic [1:0] C_START = 2'd0, C_PAUSE = 2'd1, C_RESUME = 2'd2, C_ABORT = 2'd3;

    typedef struct {
        logic [7:0] cnt;
        logic [1:0] st;
        logic       ex;
        logic       irq;
        logic       rdy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_load;
    logic       cmd_periodic;
    logic [7:0] count;
    logic [1:0] state_o;
    logic       expire;
    logic       irq;
    logic       irq_clr;

    int   checks   = 0;
    int   failures = 0;
    int   cyc_no   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    down_timer_ctrl #(.WIDTH(8), .PRESC_DIV(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_load     (cmd_load),
        .cmd_periodic (cmd_periodic),
        .count        (count),
        .state_o      (state_o),
        .expire       (expire),
        .irq          (irq),
        .irq_clr      (irq_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d got=%0h want=%0h", tag, cyc_no, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the outputs expected in that cycle, then compare at negedge.
    task automatic step(input logic v, input logic [1:0] op, input logic [7:0] ld,
                        input logic per, input logic clr,
                        input logic [7:0] e_cnt, input logic [1:0] e_st,
                        input logic e_ex, input logic e_irq, input logic e_rdy);
        exp_t e;
        cmd_valid    = v;
        cmd_op       = op;
        cmd_load     = ld;
        cmd_periodic = per;
        irq_clr      = clr;
        sb.push_back('{cnt: e_cnt, st: e_st, ex: e_ex, irq: e_irq, rdy: e_rdy});
        @(negedge clk);
        e = sb.pop_front();
        check("count",     {24'd0, count},     {24'd0, e.cnt});
        check("state",     {30'd0, state_o},   {30'd0, e.st});
        check("expire",    {31'd0, expire},    {31'd0, e.ex});
        check("irq",       {31'd0, irq},       {31'd0, e.irq});
        check("cmd_ready", {31'd0, cmd_ready}, {31'd0, e.rdy});
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    task automatic nop(input logic [7:0] c, input logic [1:0] s, input logic x, input logic i, input logic r);
        step(1'b0, 2'd0, 8'd0, 1'b0, 1'b0, c, s, x, i, r);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_load = 8'd0; cmd_periodic = 1'b0; irq_clr = 1'b0;
        @(posedge clk);
        #1;
        nop(0, S_IDLE, 0, 0, 0);
        rst = 1'b0;
`ifdef DTC_PRESCALER_EN
        step(1, C_START, 8'd1, 0, 0, 0, S_IDLE, 0, 0, 1);
        for (int k = 0; k < 4; k++) nop(1, S_RUN, 0, 0, 1);
        for (int k = 0; k < 3; k++) nop(0, S_RUN, 0, 0, 1);
        nop(0, S_RUN, 1, 0, 0);
        nop(0, S_DONE, 0, 1, 1);
        nop(0, S_DONE, 0, 1, 1);
`else
        // One-shot load 3.
        step(1, C_START, 8'd3, 0, 0, 0, S_IDLE, 0, 0, 1);
        nop(3, S_RUN, 0, 0, 1);
        nop(2, S_RUN, 0, 0, 1);
        nop(1, S_RUN, 0, 0, 1);
        nop(0, S_RUN, 1, 0, 0);
        nop(0, S_DONE, 0, 1, 1);
        step(0, 2'd0, 8'd0, 0, 1, 0, S_DONE, 0, 1, 1);
        nop(0, S_DONE, 0, 0, 1);

        // Periodic load 2, irq_clr against expire, command held across a not-ready cycle.
        step(1, C_START, 8'd2, 1, 0, 0, S_DONE, 0, 0, 1);
        nop(2, S_RUN, 0, 0, 1);
        nop(1, S_RUN, 0, 0, 1);
        nop(0, S_RUN, 1, 0, 0);
        nop(2, S_RUN, 0, 1, 1);
        nop(1, S_RUN, 0, 1, 1);
        step(0, 2'd0, 8'd0, 0, 1, 0, S_RUN, 1, 1, 0);
        step(0, 2'd0, 8'd0, 0, 1, 2, S_RUN, 0, 1, 1);
        nop(1, S_RUN, 0, 0, 1);
        step(1, C_PAUSE, 8'd0, 0, 0, 0, S_RUN, 1, 0, 0);
        step(1, C_PAUSE, 8'd0, 0, 0, 2, S_RUN, 0, 1, 1);
        nop(2, S_PAUSE, 0, 1, 1);
        step(1, C_ABORT, 8'd0, 0, 0, 2, S_PAUSE, 0, 1, 1);
        nop(0, S_IDLE, 0, 1, 1);

        // Pause at 6 for five cycles, resume, expire seven cycles later.
        step(1, C_START, 8'd10, 0, 1, 0, S_IDLE, 0, 1, 1);
        nop(10, S_RUN, 0, 0, 1);
        nop(9, S_RUN, 0, 0, 1);
        nop(8, S_RUN, 0, 0, 1);
        nop(7, S_RUN, 0, 0, 1);
        step(1, C_PAUSE, 8'd0, 0, 0, 6, S_RUN, 0, 0, 1);
        for (int k = 0; k < 4; k++) nop(6, S_PAUSE, 0, 0, 1);
        step(1, C_RESUME, 8'd0, 0, 0, 6, S_PAUSE, 0, 0, 1);
        for (int k = 6; k > 0; k--) nop(8'(k), S_RUN, 0, 0, 1);
        nop(0, S_RUN, 1, 0, 0);
        nop(0, S_DONE, 0, 1, 1);

        // Abort mid-run, then load 0 expires on the first RUN cycle.
        step(1, C_START, 8'd5, 0, 0, 0, S_DONE, 0, 1, 1);
        nop(5, S_RUN, 0, 1, 1);
        nop(4, S_RUN, 0, 1, 1);
        step(1, C_ABORT, 8'd0, 0, 0, 3, S_RUN, 0, 1, 1);
        step(0, 2'd0, 8'd0, 0, 1, 0, S_IDLE, 0, 1, 1);
        step(1, C_START, 8'd0, 0, 0, 0, S_IDLE, 0, 0, 1);
        nop(0, S_RUN, 1, 0, 0);
        nop(0, S_DONE, 0, 1, 1);

        // Synchronous reset mid-run at count 4.
        step(1, C_START, 8'd6, 1, 0, 0, S_DONE, 0, 1, 1);
        nop(6, S_RUN, 0, 1, 1);
        nop(5, S_RUN, 0, 1, 1);
        rst = 1'b1;
        nop(4, S_RUN, 0, 1, 0);
        rst = 1'b0;
        nop(0, S_IDLE, 0, 0, 1);
        step(1, C_PAUSE, 8'd0, 0, 0, 0, S_IDLE, 0, 0, 1);
        nop(0, S_IDLE, 0, 0, 1);
`endif
        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_drain left=%0d want=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
